// File: rtl/miner_pkg.sv
// Shared types and helpers for the nonce dispatcher block.
package miner_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HIT, DONE} state_t;

  localparam int DEF_NONCE_W = 32;
  localparam int DEF_PAD_W   = 44;

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/nonce_lane_gen.sv
// Combinational fan-out of one base nonce into LANES consecutive nonces.
// Padded output only exists when NONCE_DISPATCH_PAD_EN is defined.
module nonce_lane_gen
  import miner_pkg::*;
#(
  parameter int NONCE_W = DEF_NONCE_W,
  parameter int PAD_W   = DEF_PAD_W,
  parameter int LANES   = 4,
  parameter logic [PAD_W-NONCE_W-1:0] PAD_VALUE = '0
) (
  input  logic                     en,
  input  logic [NONCE_W:0]         base,
  input  logic [NONCE_W-1:0]       last,
  output logic [LANES-1:0]         lane_mask,
  output logic [LANES*NONCE_W-1:0] nonce_bus,
  output logic [LANES*PAD_W-1:0]   padded_bus
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [NONCE_W:0] n;
    // Extended compare so lanes past an all-ones range_last never alias to 0.
    assign n            = base + (NONCE_W+1)'(i);
    assign lane_mask[i] = en && (n <= {1'b0, last});
    assign nonce_bus[i*NONCE_W +: NONCE_W] = lane_mask[i] ? n[NONCE_W-1:0] : '0;
`ifdef NONCE_DISPATCH_PAD_EN
    assign padded_bus[i*PAD_W +: PAD_W] = lane_mask[i] ? {PAD_VALUE, n[NONCE_W-1:0]} : '0;
`endif
  end

`ifndef NONCE_DISPATCH_PAD_EN
  assign padded_bus = '0;
`endif

endmodule

// File: rtl/nonce_dispatcher.sv
// Splits an inclusive nonce range across LANES hash cores, stopping on
// exhaustion, abort or first hit. Optional pad logic: NONCE_DISPATCH_PAD_EN.
module nonce_dispatcher
  import miner_pkg::*;
#(
  parameter int NONCE_W = DEF_NONCE_W,
  parameter int PAD_W   = DEF_PAD_W,
  parameter int LANES   = 4,
  parameter logic [PAD_W-NONCE_W-1:0] PAD_VALUE = '0
) (
  input  logic                     osc_clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NONCE_W-1:0]       range_start,
  input  logic [NONCE_W-1:0]       range_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0]         lane_mask,
  output logic [LANES*NONCE_W-1:0] nonce_bus,
  output logic [LANES*PAD_W-1:0]   padded_bus,
  input  logic                     hit_valid,
  input  logic [NONCE_W-1:0]       hit_nonce,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic [NONCE_W-1:0]       found_nonce,
  output logic [NONCE_W:0]         issued_cnt
);

  state_t             state;
  logic [NONCE_W:0]   base;
  logic [NONCE_W:0]   base_next;
  logic [NONCE_W-1:0] last;
  logic [15:0]        mask16;
  logic               xfer;

  assign out_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign found     = (state == HIT);
  assign xfer      = out_valid && out_ready;
  assign base_next = base + (NONCE_W+1)'(LANES);

  always_comb begin
    mask16 = '0;
    mask16[LANES-1:0] = lane_mask;
  end

  nonce_lane_gen #(
    .NONCE_W(NONCE_W), .PAD_W(PAD_W), .LANES(LANES), .PAD_VALUE(PAD_VALUE)
  ) u_lane_gen (
    .en        (state == RUN),
    .base      (base),
    .last      (last),
    .lane_mask (lane_mask),
    .nonce_bus (nonce_bus),
    .padded_bus(padded_bus)
  );

  always_ff @(posedge osc_clk) begin
    if (reset || abort) begin
      state       <= IDLE;
      base        <= '0;
      last        <= '0;
      issued_cnt  <= '0;
      found_nonce <= '0;
    end else if (start && state != RUN) begin
      base        <= {1'b0, range_start};
      last        <= range_last;
      issued_cnt  <= '0;
      found_nonce <= '0;
      state       <= (range_start > range_last) ? DONE : RUN;
    end else if (state == RUN) begin
      if (xfer) begin
        issued_cnt <= issued_cnt + (NONCE_W+1)'(popcount(mask16));
        base       <= base_next;
      end
      // A hit wins over exhaustion when both land in the same cycle.
      if (hit_valid) begin
        state       <= HIT;
        found_nonce <= hit_nonce;
      end else if (xfer && base_next > {1'b0, last}) begin
        state <= DONE;
      end
    end
  end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Directed self-checking bench for nonce_dispatcher (LANES=4, 32-bit nonces).
module tb_nonce_dispatcher;

  logic         osc_clk = 0;
  logic         reset, start, abort, out_ready, hit_valid;
  logic [31:0]  range_start, range_last, hit_nonce;
  logic         out_valid, busy, done, found;
  logic [3:0]   lane_mask;
  logic [127:0] nonce_bus;
  logic [175:0] padded_bus;
  logic [31:0]  found_nonce;
  logic [32:0]  issued_cnt;

  int total = 0;
  int bad   = 0;

  always #5 osc_clk = ~osc_clk;

  nonce_dispatcher dut (
    .osc_clk(osc_clk), .reset(reset), .start(start), .abort(abort),
    .range_start(range_start), .range_last(range_last),
    .out_valid(out_valid), .out_ready(out_ready), .lane_mask(lane_mask),
    .nonce_bus(nonce_bus), .padded_bus(padded_bus),
    .hit_valid(hit_valid), .hit_nonce(hit_nonce),
    .busy(busy), .done(done), .found(found),
    .found_nonce(found_nonce), .issued_cnt(issued_cnt)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [175:0] exp_pad(input logic [127:0] nb, input logic [3:0] m);
    logic [175:0] r;
    r = '0;
`ifdef NONCE_DISPATCH_PAD_EN
    for (int i = 0; i < 4; i++)
      if (m[i]) r[i*44 +: 44] = {12'h000, nb[i*32 +: 32]};
`endif
    return r;
  endfunction

  // Advance one clock; inputs and checks happen 1 time unit after the edge.
  task automatic step();
    @(posedge osc_clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic v, input logic b,
                           input logic d, input logic f, input logic [32:0] cnt);
    chk({tag, ".valid"}, out_valid, v);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".done"}, done, d);
    chk({tag, ".found"}, found, f);
    chk({tag, ".issued"}, issued_cnt, cnt);
  endtask

  task automatic chk_beat(input string tag, input logic [3:0] m, input logic [127:0] nb);
    chk({tag, ".mask"}, lane_mask, m);
    chk({tag, ".bus"}, nonce_bus, nb);
    chk({tag, ".pad"}, padded_bus, exp_pad(nb, m));
  endtask

  task automatic do_start(input logic [31:0] s, input logic [31:0] l);
    range_start = s; range_last = l; start = 1;
    step();
    start = 0;
  endtask

  initial begin
    reset = 1; start = 0; abort = 0; out_ready = 0; hit_valid = 0;
    range_start = 0; range_last = 0; hit_nonce = 0;
    step(); step();
    reset = 0;
    chk_flags("reset", 0, 0, 0, 0, 0);
    chk_beat("reset", 4'h0, 128'h0);
    chk("reset.found_nonce", found_nonce, 0);

    // 1: full beats 0x10..0x1B
    out_ready = 1;
    do_start(32'h10, 32'h1B);
    chk_flags("t1.b0", 1, 1, 0, 0, 0);
    chk_beat("t1.b0", 4'hF, 128'h00000013_00000012_00000011_00000010);
    step();
    chk_beat("t1.b1", 4'hF, 128'h00000017_00000016_00000015_00000014);
    chk("t1.b1.issued", issued_cnt, 4);
    step();
    chk_beat("t1.b2", 4'hF, 128'h0000001B_0000001A_00000019_00000018);
    step();
    chk_flags("t1.end", 0, 0, 1, 0, 12);
    chk_beat("t1.end", 4'h0, 128'h0);

    // 2: partial beat restart from DONE
    do_start(32'h10, 32'h12);
    chk_flags("t2.b0", 1, 1, 0, 0, 0);
    chk_beat("t2.b0", 4'b0111, 128'h00000000_00000012_00000011_00000010);
    step();
    chk_flags("t2.end", 0, 0, 1, 0, 3);

    // 3: top of the nonce space, no wrap
    do_start(32'hFFFFFFFE, 32'hFFFFFFFF);
    chk_beat("t3.b0", 4'b0011, 128'h00000000_00000000_FFFFFFFF_FFFFFFFE);
    step();
    chk_flags("t3.end", 0, 0, 1, 0, 2);
    step();
    chk_flags("t3.hold", 0, 0, 1, 0, 2);
    chk_beat("t3.hold", 4'h0, 128'h0);

    // 4: backpressure freezes payload and counters
    do_start(32'h10, 32'h1B);
    step();
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_beat("t4.stall", 4'hF, 128'h00000017_00000016_00000015_00000014);
      chk("t4.stall.issued", issued_cnt, 4);
    end
    out_ready = 1;
    step();
    chk_beat("t4.resume", 4'hF, 128'h0000001B_0000001A_00000019_00000018);
    chk("t4.resume.issued", issued_cnt, 8);
    step();
    chk_flags("t4.end", 0, 0, 1, 0, 12);

    // 5: hit on the second transfer
    do_start(32'h10, 32'h1B);
    step();
    hit_valid = 1; hit_nonce = 32'h15;
    step();
    chk_flags("t5.hit", 0, 0, 0, 1, 8);
    chk("t5.found_nonce", found_nonce, 32'h15);
    hit_nonce = 32'h99;
    step();
    chk("t5.ignored", found_nonce, 32'h15);
    chk("t5.ignored.found", found, 1);
    hit_valid = 0;
    do_start(32'h20, 32'h23);
    chk_flags("t5.restart", 1, 1, 0, 0, 0);
    chk("t5.restart.found_nonce", found_nonce, 0);
    chk_beat("t5.restart", 4'hF, 128'h00000023_00000022_00000021_00000020);
    step();
    chk_flags("t5.restart.end", 0, 0, 1, 0, 4);

    // 5b: hit coincides with the final transfer
    do_start(32'h10, 32'h13);
    hit_valid = 1; hit_nonce = 32'h12;
    step();
    hit_valid = 0;
    chk_flags("t5b", 0, 0, 0, 1, 4);
    chk("t5b.found_nonce", found_nonce, 32'h12);

    // 6: abort (beating a simultaneous start), then reset mid-run
    do_start(32'h10, 32'h1B);
    step();
    abort = 1; start = 1;
    step();
    abort = 0; start = 0;
    chk_flags("t6.abort", 0, 0, 0, 0, 0);
    chk_beat("t6.abort", 4'h0, 128'h0);
    do_start(32'h10, 32'h1B);
    step();
    reset = 1;
    step();
    reset = 0;
    chk_flags("t6.reset", 0, 0, 0, 0, 0);
    chk_beat("t6.reset", 4'h0, 128'h0);

    // empty range goes straight to DONE
    do_start(32'h20, 32'h10);
    chk_flags("t6.empty", 0, 0, 1, 0, 0);
    step();
    chk_flags("t6.empty.hold", 0, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
